song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer.sv | 138 +++++++++++++
 tb/tb_song_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song sequencer: walks a pitch/duration ROM and drives a tone generator.
// All outputs are registered from the next-state logic.
module song_sequencer #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int SONG_LEN = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        restart,
    output logic [10:0] note_index,
    input  logic [6:0]  note_pitch,
    input  logic [15:0] note_duration,
    output logic [6:0]  pitch_out,
    output logic        note_start,
    output logic        song_done
);

    localparam int              PDIV = CLK_HZ / TICK_HZ;
    localparam int              PW   = (PDIV > 1) ? $clog2(PDIV) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(PDIV - 1);
    localparam logic [10:0]     LAST = 11'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PLAY,
        PAUSE,
        DONE
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc, presc_n;
    logic [15:0]     dur_cnt, dur_n;
    logic [6:0]      pitch_reg, pitch_reg_n;
    logic [10:0]     idx_n;
    logic [6:0]      pitch_n;
    logic            start_n;
    logic            done_n;
    logic            tick;
    logic            last;

    assign tick = (presc == PMAX);
    assign last = (note_index == LAST);

    // Next-state, counter and registered-output values
    always_comb begin
        state_n     = state;
        idx_n       = note_index;
        presc_n     = presc;
        dur_n       = dur_cnt;
        pitch_reg_n = pitch_reg;
        start_n     = 1'b0;
        if (restart) begin
            idx_n   = '0;
            presc_n = '0;
            dur_n   = '0;
            state_n = play ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (play) state_n = FETCH;
                end
                FETCH: begin
                    pitch_reg_n = note_pitch;
                    dur_n       = note_duration;
                    presc_n     = '0;
                    if (note_duration == 16'd0) begin
                        if (last) begin
                            state_n = DONE;
                        end else begin
                            idx_n   = note_index + 11'd1;
                            state_n = FETCH;
                        end
                    end else begin
                        state_n = PLAY;
                        start_n = 1'b1;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        presc_n = '0;
                        dur_n   = dur_cnt - 16'd1;
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                    // The cycle that sees play=0 still counts toward the note
                    if (tick && dur_cnt == 16'd1) begin
                        if (last) begin
                            state_n = DONE;
                        end else begin
                            idx_n   = note_index + 11'd1;
                            state_n = FETCH;
                        end
                    end else if (!play) begin
                        state_n = PAUSE;
                    end
                end
                PAUSE: begin
                    if (play) state_n = PLAY;
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        pitch_n = (state_n == PLAY) ? pitch_reg_n : 7'd0;
        done_n  = (state_n == DONE);
    end

    // State, counters and outputs register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            note_index <= '0;
            presc      <= '0;
            dur_cnt    <= '0;
            pitch_reg  <= '0;
            pitch_out  <= '0;
            note_start <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            state      <= state_n;
            note_index <= idx_n;
            presc      <= presc_n;
            dur_cnt    <= dur_n;
            pitch_reg  <= pitch_reg_n;
            pitch_out  <= pitch_n;
            note_start <= start_n;
            song_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: 3-entry ROM, 10 cycles per tick.
// Expected traces come from a note-list model built from the ROM contents.
module tb_song_sequencer;

    localparam int P = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        restart;
    logic [10:0] note_index;
    logic [6:0]  note_pitch;
    logic [15:0] note_duration;
    logic [6:0]  pitch_out;
    logic        note_start;
    logic        song_done;

    logic [6:0]  rp[3];
    logic [15:0] rd[3];

    logic [6:0]  ep[$];
    bit          es[$];
    bit          ed[$];
    logic [10:0] ei[$];

    int checks = 0;
    int errors = 0;

    song_sequencer #(
        .CLK_HZ(10),
        .TICK_HZ(1),
        .SONG_LEN(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .play(play),
        .restart(restart),
        .note_index(note_index),
        .note_pitch(note_pitch),
        .note_duration(note_duration),
        .pitch_out(pitch_out),
        .note_start(note_start),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    // Combinational ROM model
    always_comb begin
        note_pitch    = 7'd0;
        note_duration = 16'd0;
        if (note_index < 11'd3) begin
            note_pitch    = rp[note_index[1:0]];
            note_duration = rd[note_index[1:0]];
        end
    end

    task automatic set_rom(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [15:0] d0,
                           input logic [15:0] d1, input logic [15:0] d2);
        rp[0] = p0; rp[1] = p1; rp[2] = p2;
        rd[0] = d0; rd[1] = d1; rd[2] = d2;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        play    = 1'b0;
        restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Per-cycle expectation from edge 1 after release: each note is one
    // silent fetch cycle, then D*P cycles of its pitch, then DONE.
    task automatic build_model();
        ep.delete(); es.delete(); ed.delete(); ei.delete();
        for (int i = 0; i < 3; i++) begin
            ep.push_back(7'd0); es.push_back(1'b0);
            ed.push_back(1'b0); ei.push_back(11'(i));
            for (int c = 0; c < int'(rd[i]) * P; c++) begin
                ep.push_back(rp[i]); es.push_back(c == 0);
                ed.push_back(1'b0); ei.push_back(11'(i));
            end
        end
        repeat (3) begin
            ep.push_back(7'd0); es.push_back(1'b0);
            ed.push_back(1'b1); ei.push_back(11'd2);
        end
    endtask

    function automatic int song_cycles();
        int s = 0;
        for (int i = 0; i < 3; i++) s += 1 + int'(rd[i]) * P;
        return s;
    endfunction

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; restart = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pitch_out, note_start, song_done, note_index} !== 20'd0) begin
            errors++;
            $display("FAIL reset_state got p=%0d s=%0b d=%0b i=%0d want all 0",
                     pitch_out, note_start, song_done, note_index);
        end
        restart = 1'b0;
    endtask

    // Fixed songs, the skip case and random ROMs against the model
    task automatic test_songs();
        for (int r = 0; r < 14; r++) begin
            int n77 = 0, n75 = 0, ns = 0, last77 = 0, first75 = 0;
            if (r == 0) set_rom(7'd77, 7'd0, 7'd75, 16'd2, 16'd1, 16'd3);
            else if (r == 1) set_rom(7'd77, 7'd0, 7'd75, 16'd2, 16'd0, 16'd3);
            else set_rom(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                         7'($urandom_range(0, 127)), 16'($urandom_range(0, 3)),
                         16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
            build_model();
            do_reset();
            play = 1'b1;
            for (int n = 0; n < ep.size(); n++) begin
                @(posedge clk);
                #1;
                if (pitch_out == 7'd77) begin n77++; last77 = n; end
                if (pitch_out == 7'd75 && n75 == 0) first75 = n;
                if (pitch_out == 7'd75) n75++;
                if (note_start) ns++;
                checks++;
                if ({pitch_out, note_start, song_done, note_index} !==
                    {ep[n], es[n], ed[n], ei[n]}) begin
                    errors++;
                    $display("FAIL trace r=%0d cyc=%0d got p=%0d s=%0b d=%0b i=%0d want p=%0d s=%0b d=%0b i=%0d",
                             r, n, pitch_out, note_start, song_done, note_index,
                             ep[n], es[n], ed[n], ei[n]);
                end
            end
            if (r == 0) begin
                checks++;
                if (n77 != 20 || n75 != 30 || ns != 3) begin
                    errors++;
                    $display("FAIL basic_counts got n77=%0d n75=%0d starts=%0d want 20 30 3",
                             n77, n75, ns);
                end
            end
            if (r == 1) begin
                checks++;
                if (first75 - last77 - 1 != 2 || ns != 2) begin
                    errors++;
                    $display("FAIL skip got gap=%0d starts=%0d want gap=2 starts=2",
                             first75 - last77 - 1, ns);
                end
            end
        end
    endtask

    task automatic test_pause();
        int k, n77 = 0, ns = 0, tot;
        set_rom(7'd77, 7'd0, 7'd75, 16'd2, 16'd1, 16'd3);
        k   = $urandom_range(2, 15);
        tot = song_cycles() + 7 + 3;
        do_reset();
        play = 1'b1;
        for (int e = 1; e <= tot; e++) begin
            @(posedge clk);
            #1;
            if (pitch_out == 7'd77) n77++;
            if (note_start) ns++;
            if (e > k && e <= k + 7) begin
                checks++;
                if (pitch_out !== 7'd0 || note_index !== 11'd0) begin
                    errors++;
                    $display("FAIL pause_silent e=%0d got p=%0d i=%0d want p=0 i=0",
                             e, pitch_out, note_index);
                end
            end
            if (e == k) play = 1'b0;
            if (e == k + 7) play = 1'b1;
        end
        checks++;
        if (n77 != 20 || ns != 3 || song_done !== 1'b1) begin
            errors++;
            $display("FAIL pause_totals got n77=%0d starts=%0d done=%0b want 20 3 1",
                     n77, ns, song_done);
        end
    endtask

    task automatic test_restart_done();
        set_rom(7'd77, 7'd0, 7'd75, 16'd2, 16'd1, 16'd3);
        do_reset();
        play = 1'b1;
        repeat (song_cycles() + 2) @(posedge clk);
        #1;
        checks++;
        if (song_done !== 1'b1 || pitch_out !== 7'd0) begin
            errors++;
            $display("FAIL done_state got d=%0b p=%0d want d=1 p=0",
                     song_done, pitch_out);
        end
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checks++;
        if (note_index !== 11'd0 || song_done !== 1'b0 || pitch_out !== 7'd0) begin
            errors++;
            $display("FAIL restart_fetch got i=%0d d=%0b p=%0d want i=0 d=0 p=0",
                     note_index, song_done, pitch_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pitch_out !== 7'd77 || note_start !== 1'b1 || song_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_play got p=%0d s=%0b d=%0b want p=77 s=1 d=0",
                     pitch_out, note_start, song_done);
        end
    endtask

    task automatic test_restart_tick();
        int endn1;
        set_rom(7'd77, 7'd0, 7'd75, 16'd2, 16'd1, 16'd3);
        endn1 = 1 + (1 + int'(rd[0]) * P) + int'(rd[1]) * P;
        do_reset();
        play = 1'b1;
        repeat (endn1) @(posedge clk);
        #1;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checks++;
        if (note_index !== 11'd0) begin
            errors++;
            $display("FAIL restart_tick got i=%0d want i=0", note_index);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pitch_out !== 7'd77 || note_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_tick_play got p=%0d s=%0b want p=77 s=1",
                     pitch_out, note_start);
        end
    endtask

    task automatic test_reset_mid();
        set_rom(7'd77, 7'd0, 7'd75, 16'd2, 16'd1, 16'd3);
        do_reset();
        play = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        checks++;
        if (pitch_out !== 7'd75 || note_index !== 11'd2) begin
            errors++;
            $display("FAIL mid_note2 got p=%0d i=%0d want p=75 i=2",
                     pitch_out, note_index);
        end
        reset = 1'b1; restart = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({pitch_out, note_start, song_done, note_index} !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid got p=%0d s=%0b d=%0b i=%0d want all 0",
                     pitch_out, note_start, song_done, note_index);
        end
        reset = 1'b0; restart = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (pitch_out !== 7'd0 || note_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got p=%0d s=%0b want p=0 s=0",
                     pitch_out, note_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pitch_out !== 7'd77 || note_start !== 1'b1 || note_index !== 11'd0) begin
            errors++;
            $display("FAIL reset_resume got p=%0d s=%0b i=%0d want p=77 s=1 i=0",
                     pitch_out, note_start, note_index);
        end
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; restart = 1'b0;
        set_rom(7'd77, 7'd0, 7'd75, 16'd2, 16'd1, 16'd3);
        test_reset();
        test_songs();
        test_pause();
        test_restart_done();
        test_restart_tick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
